welcome_arbiter: RTL and testbench

Round-robin arbiter that shares one "Hello" pattern detector among `N_REQ` byte-stream requesters. It grants one requester at a time for a burst of up to `BURST_LEN` bytes and forwards accepted bytes to the detector. It clears the detector between owners so a pattern never spans two requesters, and routes each detector hit back to the requester that owned the byte.

---
 rtl/welcome_pkg.sv | 23 ++
 rtl/welcome_arbiter_rr_pick.sv | 42 ++++
 rtl/welcome_arbiter.sv | 168 ++++++++++++++++
 tb/tb_welcome_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/welcome_pkg.sv
// rtl/welcome_pkg.sv - shared types and constants for the welcome_arbiter slice
package welcome_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_OWN    = 3'b010,
        ST_SWITCH = 3'b100
    } state_t;

    localparam logic [7:0] ASCII_H = 8'h48;
    localparam logic [7:0] ASCII_E = 8'h65;
    localparam logic [7:0] ASCII_L = 8'h6C;
    localparam logic [7:0] ASCII_O = 8'h6F;

    localparam int DEFAULT_BURST_LEN = 8;
    localparam int DEFAULT_TIMEOUT   = 16;

    // Index width that stays at least one bit for the smallest requester count.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/welcome_arbiter_rr_pick.sv
// rtl/welcome_arbiter_rr_pick.sv - round-robin first-set-bit search from a pointer
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IW:0]        w_sum;

    // Rotating a doubled copy puts the pointer position at bit 0, so the
    // first set bit of w_rot is the winner's distance from the pointer.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N_REQ'(w_dbl >> i_ptr);

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        o_gnt = '0;
        w_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N_REQ)) begin
                    w_sum = w_sum - (IW+1)'(N_REQ);
                end
                o_idx = w_sum[IW-1:0];
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            o_gnt[k] = o_any && (o_idx == IW'(k));
        end
    end

endmodule

// File: rtl/welcome_arbiter.sv
// rtl/welcome_arbiter.sv - round-robin share of one "Hello" detector among byte streams
// Optional idle-grant release is enabled by defining WELCOME_ARB_TIMEOUT_EN.
module welcome_arbiter
    import welcome_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   src_valid,
    input  logic [8*N_REQ-1:0] src_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ready,
    output logic [7:0]         det_data,
    output logic               det_valid,
    output logic               det_clr,
    input  logic               det_hit,
    output logic [N_REQ-1:0]   hit
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic [7:0]       r_det_data;
    logic             r_det_valid;
    logic             r_det_clr;
    logic [IW-1:0]    r_det_owner;
    logic [N_REQ-1:0] r_hit;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_accept;
    logic             w_owner_req;
    logic [7:0]       w_beat;
    logic [CW-1:0]    w_count_next;
    logic             w_burst_done;
    logic             w_drop;
    logic             w_timeout;
    logic             w_end;
    logic [IW-1:0]    w_ptr_next;
    logic [N_REQ-1:0] w_hit_vec;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign gnt       = r_gnt;
    assign ready     = (r_state == ST_OWN) ? r_gnt : '0;
    assign det_data  = r_det_data;
    assign det_valid = r_det_valid;
    assign det_clr   = r_det_clr;
    assign hit       = r_hit;

    assign w_accept     = |(ready & src_valid);
    assign w_owner_req  = |(r_gnt & req);
    assign w_count_next = r_count + CW'(1);
    assign w_burst_done = w_accept && (w_count_next == CW'(BURST_LEN));
    assign w_drop       = !w_accept && !w_owner_req;
    assign w_end        = w_burst_done || w_drop || w_timeout;
    assign w_ptr_next   = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);

    always_comb begin
        w_beat = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gnt[k]) begin
                w_beat = src_data[8*k +: 8];
            end
        end
    end

    // det_hit qualifies the byte currently on det_data, so route it by that byte's owner.
    always_comb begin
        w_hit_vec = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_hit_vec[k] = r_det_valid && det_hit && (r_det_owner == IW'(k));
        end
    end

`ifdef WELCOME_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;

    assign w_timeout = (r_state == ST_OWN) && !w_accept && (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_OWN) || w_accept) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_det_data  <= 8'h00;
            r_det_valid <= 1'b0;
            r_det_clr   <= 1'b0;
            r_det_owner <= '0;
            r_hit       <= '0;
        end else begin
            r_hit       <= w_hit_vec;
            r_det_valid <= 1'b0;
            r_det_clr   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_gnt;
                        r_owner <= w_pick_idx;
                        r_count <= '0;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_accept) begin
                        r_det_data  <= w_beat;
                        r_det_valid <= 1'b1;
                        r_det_owner <= r_owner;
                        r_count     <= w_count_next;
                    end
                    // The final byte and the clear leave together; the detector
                    // consumes the byte before honouring the clear.
                    if (w_end) begin
                        r_gnt     <= '0;
                        r_det_clr <= 1'b1;
                        r_state   <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_welcome_arbiter.sv
// tb/tb_welcome_arbiter.sv - self-checking bench for welcome_arbiter with a model detector
module tb_welcome_arbiter;
    import welcome_pkg::*;

    localparam int N  = 4;
    localparam int BL = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  src_valid;
    logic [8*N-1:0] src_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ready;
    logic [7:0]    det_data;
    logic          det_valid;
    logic          det_clr;
    logic          det_hit;
    logic [N-1:0]  hit;

    welcome_arbiter #(
        .N_REQ     (N),
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_valid (src_valid),
        .src_data  (src_data),
        .gnt       (gnt),
        .ready     (ready),
        .det_data  (det_data),
        .det_valid (det_valid),
        .det_clr   (det_clr),
        .det_hit   (det_hit),
        .hit       (hit)
    );

    always #5 clk = ~clk;

    // Model detector: remembers the last four bytes, processes a byte before a clear.
    logic [31:0] m_hist;
    assign det_hit = det_valid && (det_data == ASCII_O) &&
                     (m_hist == {ASCII_H, ASCII_E, ASCII_L, ASCII_L});

    always @(posedge clk) begin
        if (rst || det_clr) m_hist <= 32'd0;
        else if (det_valid) m_hist <= {m_hist[23:0], det_data};
    end

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] b;
    } beat_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    beat_t      sb_q[$];
    beat_t      mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         hit_cnt[N];
    int         clr_cnt  = 0;
    logic [3:0] exp_hit  = 4'd0;
    vec_t       tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int cyc);
        logic ok;
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_wait: got no grant expected grant within 20 cycles");
        end
    endtask

    task automatic send(input int r, input logic [7:0] b);
        beat_t e;
        check("ready_before_beat", 32'(ready[r]), 32'd1);
        e.own = 2'(r);
        e.b   = b;
        sb_q.push_back(e);
        src_valid[r]        = 1'b1;
        src_data[8*r +: 8]  = b;
        tick();
        src_valid[r] = 1'b0;
    endtask

    always @(negedge clk) begin
        check("hit_route", 32'(hit), 32'(exp_hit));
        for (int i = 0; i < N; i++) if (hit[i]) hit_cnt[i]++;
        if (det_clr) clr_cnt++;
        exp_hit = 4'd0;
        if (det_valid) begin
            if (sb_q.size() == 0) begin
                check("det_valid_unexpected", 32'(det_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("det_data", 32'(det_data), 32'(mon_e.b));
                if (det_hit) exp_hit[mon_e.own] = 1'b1;
            end
        end
        if (rst) begin
            sb_q.delete();
            exp_hit = 4'd0;
        end
    end

    initial begin
        int cyc;
        int h0;
        int c0;
        int held;
        logic [7:0] hello [5];

        for (int i = 0; i < N; i++) hit_cnt[i] = 0;
        hello[0] = ASCII_H; hello[1] = ASCII_E; hello[2] = ASCII_L;
        hello[3] = ASCII_L; hello[4] = ASCII_O;

        tbl[0] = '{4'b1010, 4'b0010};
        tbl[1] = '{4'b1010, 4'b1000};
        tbl[2] = '{4'b0001, 4'b0001};
        tbl[3] = '{4'b0001, 4'b0001};
        tbl[4] = '{4'b1100, 4'b0100};
        tbl[5] = '{4'b0110, 4'b0010};
        tbl[6] = '{4'b1111, 4'b0100};
        tbl[7] = '{4'b1111, 4'b1000};

        rst = 1'b1; req = '0; src_valid = '0; src_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_det_valid", 32'(det_valid), 32'd0);
        check("rst_det_clr", 32'(det_clr), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_det_data", 32'(det_data), 32'd0);

        // Beats without any grant must never reach the detector.
        src_valid = 4'hF; src_data = 32'h6F6C6548;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("nognt_det_valid", 32'(det_valid), 32'd0);
            check("nognt_gnt", 32'(gnt), 32'd0);
        end
        src_valid = '0;

        for (int k = 0; k < 8; k++) begin
            req = tbl[k].req;
            tick();
            check("tbl_gnt", 32'(gnt), 32'(tbl[k].gnt));
            check("tbl_ready", 32'(ready), 32'(tbl[k].gnt));
            req = '0;
            tick();
            check("tbl_switch_gnt", 32'(gnt), 32'd0);
            check("tbl_switch_clr", 32'(det_clr), 32'd1);
            tick();
            check("tbl_idle_clr", 32'(det_clr), 32'd0);
        end

        // Hello from requester 0.
        h0 = hit_cnt[0];
        req = 4'b0001;
        tick();
        check("hello_gnt", 32'(gnt), 32'b0001);
        for (int k = 0; k < 5; k++) send(0, hello[k]);
        req = '0;
        repeat (4) tick();
        check("hello_hit0", 32'(hit_cnt[0] - h0), 32'd1);

        // Requesters 0 and 2 compete; pointer sits at 1 so 2 wins first.
        c0 = clr_cnt;
        req = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            wait_gnt(cyc);
            if (b > 0) check("alt_gap", 32'(cyc), 32'd2);
            check("alt_gnt", 32'(gnt), (b % 2 == 0) ? 32'b0100 : 32'b0001);
            for (int k = 0; k < BL; k++) send((b % 2 == 0) ? 2 : 0, 8'(8'h20 + b * 8 + k));
            check("alt_end_gnt", 32'(gnt), 32'd0);
            check("alt_end_clr", 32'(det_clr), 32'd1);
            if (b == 3) req = '0;
        end
        repeat (3) tick();
        check("alt_clr_count", 32'(clr_cnt - c0), 32'd4);

        // "Hel" from 1, then "lo" from 3: the clear separates them.
        h0 = hit_cnt[0] + hit_cnt[1] + hit_cnt[2] + hit_cnt[3];
        c0 = clr_cnt;
        req = 4'b0010;
        tick();
        check("split_gnt1", 32'(gnt), 32'b0010);
        for (int k = 0; k < 3; k++) send(1, hello[k]);
        req = 4'b1000;
        tick();
        check("split_drop_clr", 32'(det_clr), 32'd1);
        check("split_drop_gnt", 32'(gnt), 32'd0);
        wait_gnt(cyc);
        check("split_gnt3", 32'(gnt), 32'b1000);
        send(3, hello[3]);
        send(3, hello[4]);
        req = '0;
        repeat (4) tick();
        check("split_no_hit", 32'(hit_cnt[0] + hit_cnt[1] + hit_cnt[2] + hit_cnt[3] - h0), 32'd0);
        check("split_clr_count", 32'(clr_cnt - c0), 32'd2);

        // Move the pointer to 3, then reset during a burst from 2.
        req = 4'b0100;
        tick();
        check("pre_rst_gnt_a", 32'(gnt), 32'b0100);
        req = '0;
        repeat (3) tick();
        req = 4'b0100;
        tick();
        check("pre_rst_gnt_b", 32'(gnt), 32'b0100);
        send(2, 8'h31);
        send(2, 8'h32);
        src_valid[2] = 1'b1; src_data[23:16] = 8'h33; rst = 1'b1;
        tick();
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_det_valid", 32'(det_valid), 32'd0);
        check("midrst_det_clr", 32'(det_clr), 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        rst = 1'b0; src_valid = '0; req = 4'b1111;
        tick();
        check("post_rst_ptr", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) tick();

        // Requester 3 ends a full burst with "Hello".
        req = 4'b1000;
        tick();
        check("last_gnt3", 32'(gnt), 32'b1000);
        for (int k = 0; k < 3; k++) send(3, 8'(8'h41 + k));
        for (int k = 0; k < 5; k++) send(3, hello[k]);
        check("last_switch_gnt", 32'(gnt), 32'd0);
        check("last_switch_clr", 32'(det_clr), 32'd1);
        check("last_switch_valid", 32'(det_valid), 32'd1);
        check("last_switch_data", 32'(det_data), 32'h6F);
        req = 4'b1001;
        tick();
        check("last_hit3", 32'(hit), 32'b1000);
        tick();
        check("wrap_to_0", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) tick();

        // Lone requester keeps asking: regranted after two idle cycles.
        req = 4'b0010;
        wait_gnt(cyc);
        check("alone_gnt_a", 32'(gnt), 32'b0010);
        for (int k = 0; k < BL; k++) send(1, 8'(8'h50 + k));
        check("alone_end_clr", 32'(det_clr), 32'd1);
        wait_gnt(cyc);
        check("alone_gap", 32'(cyc), 32'd2);
        check("alone_gnt_b", 32'(gnt), 32'b0010);
        req = '0;
        repeat (3) tick();

        // Requester holds req with no data.
        req = 4'b0010;
        tick();
        check("hold_gnt", 32'(gnt), 32'b0010);
        held = 0;
`ifdef WELCOME_ARB_TIMEOUT_EN
        while (gnt != '0 && held < 200) begin
            held++;
            tick();
        end
        check("timeout_cycles", 32'(held), 32'(TO));
`else
        for (int k = 0; k < 120; k++) begin
            if (gnt == 4'b0010) held++;
            tick();
        end
        check("hold_cycles", 32'(held), 32'd120);
`endif
        req = '0;
        repeat (4) tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
